// File: rtl/hacd_pkg.sv
// Shared types for the hawk struct read-modify-write sequencer.
// Ops, FSM state encoding and the latched command bundle.
package hacd_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_ADD   = 2'd2,
    OP_CAS   = 2'd3
  } hawk_rmw_op_t;

  typedef logic [2:0] hawk_rmw_state_t;

  localparam hawk_rmw_state_t S_IDLE    = 3'd0;
  localparam hawk_rmw_state_t S_RD      = 3'd1;
  localparam hawk_rmw_state_t S_RD_WAIT = 3'd2;
  localparam hawk_rmw_state_t S_MOD     = 3'd3;
  localparam hawk_rmw_state_t S_WR      = 3'd4;
  localparam hawk_rmw_state_t S_WR_WAIT = 3'd5;
  localparam hawk_rmw_state_t S_RESP    = 3'd6;

  localparam int HAWK_SW = 8;
  localparam int HAWK_AW = 64 - HAWK_SW;

  typedef struct packed {
    hawk_rmw_op_t         op;
    logic [HAWK_AW-1:0]   addr;
    logic [HAWK_SW-1:0]   mask;
    logic [HAWK_SW-1:0]   data;
    logic [HAWK_SW-1:0]   cmp;
  } hawk_rmw_cmd_t;

endpackage

// File: rtl/hawk_rmw_alu.sv
// New-value computation for one struct RMW command.
// Purely combinational; new_val equals old whenever no write is due.
import hacd_pkg::*;

module hawk_rmw_alu #(
  parameter int W = 8
) (
  input  hawk_rmw_op_t op,
  input  logic [W-1:0] old,
  input  logic [W-1:0] mask,
  input  logic [W-1:0] data,
  input  logic [W-1:0] cmp,
  output logic [W-1:0] new_val,
  output logic         do_write
);

  logic [W-1:0] sum;
  logic [W-1:0] src;

  // carries past the mask are dropped by the merge below
  assign sum = old + data;

  always_comb begin
    src      = data;
    do_write = 1'b0;
    unique case (op)
      OP_READ:  src = old;
      OP_WRITE: do_write = 1'b1;
      OP_ADD: begin
        src      = sum;
        do_write = 1'b1;
      end
      OP_CAS:   do_write = ((old ^ cmp) & mask) == '0;
      default:  do_write = 1'b0;
    endcase
    new_val = (old & ~mask) | (src & mask);
    if (!do_write) new_val = old;
  end

endmodule

// File: rtl/hawk_struct_rmw.sv
// Single-outstanding RMW sequencer in front of hawk_struct_rw.
// One command in flight; read, optional write, then a held response.
import hacd_pkg::*;

module hawk_struct_rmw #(
  parameter int STRUCT_WIDTH   = 8,
  parameter int ADDR_WIDTH     = 64 - STRUCT_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [STRUCT_WIDTH-1:0] cmd_mask,
  input  logic [STRUCT_WIDTH-1:0] cmd_data,
  input  logic [STRUCT_WIDTH-1:0] cmd_cmp,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [STRUCT_WIDTH-1:0] resp_old,
  output logic [STRUCT_WIDTH-1:0] resp_new,
  output logic                    resp_wrote,
  output logic                    resp_err,
  output logic [ADDR_WIDTH-1:0]   rw_r_addr_array,
  output logic [ADDR_WIDTH-1:0]   rw_w_addr_array,
  output logic                    rw_r_valid,
  output logic                    rw_w_valid,
  output logic [STRUCT_WIDTH-1:0] rw_w_array,
  input  logic [STRUCT_WIDTH-1:0] rw_r_array,
  input  logic                    rw_r_done,
  input  logic                    rw_w_done,
  input  logic                    rw_r_ready,
  input  logic                    rw_w_ready
);

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  hawk_rmw_state_t         state;
  hawk_rmw_op_t            op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [STRUCT_WIDTH-1:0] mask_q;
  logic [STRUCT_WIDTH-1:0] data_q;
  logic [STRUCT_WIDTH-1:0] cmp_q;
  logic [STRUCT_WIDTH-1:0] old_q;
  logic [STRUCT_WIDTH-1:0] new_q;
  logic                    wrote_q;
  logic                    err_q;
  logic [CW-1:0]           cnt;
  logic [STRUCT_WIDTH-1:0] alu_new;
  logic                    alu_wr;
  logic                    to_hit;

  hawk_rmw_alu #(.W(STRUCT_WIDTH)) u_alu (
    .op       (op_q),
    .old      (old_q),
    .mask     (mask_q),
    .data     (data_q),
    .cmp      (cmp_q),
    .new_val  (alu_new),
    .do_write (alu_wr)
  );

  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      cmp_q   <= '0;
      old_q   <= '0;
      new_q   <= '0;
      wrote_q <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid && cmd_ready) begin
          op_q    <= hawk_rmw_op_t'(cmd_op);
          addr_q  <= cmd_addr;
          mask_q  <= cmd_mask;
          data_q  <= cmd_data;
          cmp_q   <= cmd_cmp;
          old_q   <= '0;
          new_q   <= '0;
          wrote_q <= 1'b0;
          err_q   <= 1'b0;
          state   <= S_RD;
        end
        S_RD: if (rw_r_ready) begin
          cnt   <= '0;
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (rw_r_done) begin
            old_q <= rw_r_array;
            state <= S_MOD;
          end else if (to_hit) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MOD: begin
          new_q <= alu_new;
          state <= alu_wr ? S_WR : S_RESP;
        end
        S_WR: if (rw_w_ready) begin
          cnt   <= '0;
          state <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (rw_w_done) begin
            wrote_q <= 1'b1;
            state   <= S_RESP;
          end else if (to_hit) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: if (resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // valids follow the wait states, so they fall the cycle after done
  assign cmd_ready       = (state == S_IDLE) && !rst_i;
  assign resp_valid      = (state == S_RESP);
  assign rw_r_valid      = (state == S_RD_WAIT);
  assign rw_w_valid      = (state == S_WR_WAIT);
  assign resp_old        = old_q;
  assign resp_new        = new_q;
  assign resp_wrote      = wrote_q;
  assign resp_err        = err_q;
  assign rw_r_addr_array = addr_q;
  assign rw_w_addr_array = addr_q;
  assign rw_w_array      = new_q;

endmodule

// File: tb/tb_hawk_struct_rmw.sv
// Bench for hawk_struct_rmw with a 3-cycle struct_rw model.
// Directed scenarios plus random commands against a bitwise model.
module tb_hawk_struct_rmw;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [55:0] cmd_addr = '0;
  logic [7:0]  cmd_mask = '0;
  logic [7:0]  cmd_data = '0;
  logic [7:0]  cmd_cmp = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [7:0]  resp_old;
  logic [7:0]  resp_new;
  logic        resp_wrote;
  logic        resp_err;
  logic [55:0] rw_r_addr_array;
  logic [55:0] rw_w_addr_array;
  logic        rw_r_valid;
  logic        rw_w_valid;
  logic [7:0]  rw_w_array;
  logic [7:0]  rw_r_array;
  logic        rw_r_done;
  logic        rw_w_done;
  logic        rw_r_ready;
  logic        rw_w_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hawk_struct_rmw #(
    .STRUCT_WIDTH(8), .ADDR_WIDTH(56), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_mask(cmd_mask), .cmd_data(cmd_data), .cmd_cmp(cmd_cmp),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_old(resp_old), .resp_new(resp_new),
    .resp_wrote(resp_wrote), .resp_err(resp_err),
    .rw_r_addr_array(rw_r_addr_array),
    .rw_w_addr_array(rw_w_addr_array),
    .rw_r_valid(rw_r_valid), .rw_w_valid(rw_w_valid),
    .rw_w_array(rw_w_array), .rw_r_array(rw_r_array),
    .rw_r_done(rw_r_done), .rw_w_done(rw_w_done),
    .rw_r_ready(rw_r_ready), .rw_w_ready(rw_w_ready)
  );

  // struct_rw model: done 3 cycles after valid, ready after valid drops
  logic [7:0] mem [0:15];
  bit         hang_r = 1'b0;
  int         rph, wph, rcnt, wcnt;

  always @(posedge clk) begin
    if (rst_i) begin
      rw_r_ready <= 1'b1; rw_r_done <= 1'b0; rph <= 0; rcnt <= 0;
    end else begin
      rw_r_done <= 1'b0;
      case (rph)
        0: if (rw_r_valid) begin
          rph <= 1; rcnt <= 0; rw_r_ready <= 1'b0;
        end
        1: if (!hang_r) begin
          if (rcnt == 1) begin
            rw_r_done  <= 1'b1;
            rw_r_array <= mem[rw_r_addr_array[3:0]];
            rph <= 2;
          end else rcnt <= rcnt + 1;
        end
        default: if (!rw_r_valid) begin
          rph <= 0; rw_r_ready <= 1'b1;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst_i) begin
      rw_w_ready <= 1'b1; rw_w_done <= 1'b0; wph <= 0; wcnt <= 0;
    end else begin
      rw_w_done <= 1'b0;
      case (wph)
        0: if (rw_w_valid) begin
          wph <= 1; wcnt <= 0; rw_w_ready <= 1'b0;
        end
        1: begin
          if (wcnt == 1) begin
            rw_w_done <= 1'b1;
            mem[rw_w_addr_array[3:0]] <= rw_w_array;
            wph <= 2;
          end else wcnt <= wcnt + 1;
        end
        default: if (!rw_w_valid) begin
          wph <= 0; rw_w_ready <= 1'b1;
        end
      endcase
    end
  end

  // cycle-level monitor
  int cyc = 0;
  int r_hi = 0, w_hi = 0;
  int r_rise = 0, w_rise = 0, resp_rise = 0;
  int rdone_c = 0, wdone_c = 0;
  bit pr = 0, pw = 0, pp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rw_r_valid) r_hi = r_hi + 1;
    if (rw_w_valid) w_hi = w_hi + 1;
    if (rw_r_valid && !pr) r_rise = cyc;
    if (rw_w_valid && !pw) w_rise = cyc;
    if (resp_valid && !pp) resp_rise = cyc;
    if (rw_r_done) rdone_c = cyc;
    if (rw_w_done) wdone_c = cyc;
    pr = rw_r_valid; pw = rw_w_valid; pp = resp_valid;
  end

  int acc_cyc = 0;

  function automatic logic [7:0] ref_new(
    input int op, input int old, input int mask,
    input int data, input int cmp, output bit w
  );
    int src, res;
    src = data;
    w = 1'b1;
    if (op == 0) begin w = 1'b0; src = old; end
    if (op == 2) src = (old + data) % 256;
    if (op == 3) w = ((old % 256) & mask) == ((cmp % 256) & mask);
    res = 0;
    for (int i = 0; i < 8; i++) begin
      if ((mask >> i) & 1) res = res + (((src >> i) & 1) << i);
      else                 res = res + (((old >> i) & 1) << i);
    end
    if (!w) res = old;
    return 8'(res);
  endfunction

  task automatic run_cmd(
    input logic [1:0] op, input logic [55:0] a,
    input logic [7:0] m, input logic [7:0] d, input logic [7:0] c,
    output logic [7:0] o, output logic [7:0] n,
    output logic wr, output logic er
  );
    int k;
    o = '0; n = '0; wr = 1'b0; er = 1'b0;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_mask = m;
    cmd_data = d; cmd_cmp = c; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 200) begin @(negedge clk); k++; end
    acc_cyc = cyc;
    if (k >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_accept: ready=%0b want 1", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      @(negedge clk);
      cmd_valid = 1'b0;
      k = 0;
      while (!resp_valid && k < 200) begin @(negedge clk); k++; end
      if (k >= 200) begin
        n_cmp++; n_bad++;
        $display("FAIL resp_wait: resp_valid=%0b want 1", resp_valid);
      end else begin
        o = resp_old; n = resp_new; wr = resp_wrote; er = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
      end
    end
  endtask

  logic [7:0] o, n;
  logic       wr, er;

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, resp_valid, rw_r_valid, rw_w_valid} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_valids: got %b want 0000",
        {cmd_ready, resp_valid, rw_r_valid, rw_w_valid});
    end
    n_cmp++;
    if ({resp_old, resp_new, resp_wrote, resp_err} !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_resp: old=%h new=%h wr=%b err=%b want 0",
        resp_old, resp_new, resp_wrote, resp_err);
    end
    n_cmp++;
    if ({rw_r_addr_array, rw_w_addr_array, rw_w_array} !== 120'd0) begin
      n_bad++;
      $display("FAIL reset_addr: r=%h w=%h wa=%h want 0",
        rw_r_addr_array, rw_w_addr_array, rw_w_array);
    end
    rst_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_read();
    int w0;
    run_cmd(2'd1, 56'd5, 8'hFF, 8'h3C, 8'h00, o, n, wr, er);
    w0 = w_hi;
    run_cmd(2'd0, 56'd5, 8'h00, 8'h00, 8'h00, o, n, wr, er);
    n_cmp++;
    if (o !== 8'h3C || n !== 8'h3C || wr !== 1'b0 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL read: old=%h new=%h wr=%b err=%b want 3c 3c 0 0",
        o, n, wr, er);
    end
    n_cmp++;
    if (w_hi != w0 || rw_r_addr_array !== 56'd5) begin
      n_bad++;
      $display("FAIL read_nowrite: wcycles=%0d addr=%0d want 0 5",
        w_hi - w0, rw_r_addr_array);
    end
    n_cmp++;
    if (r_rise - acc_cyc != 2 || resp_rise - rdone_c != 2) begin
      n_bad++;
      $display("FAIL read_latency: rv=%0d resp=%0d want 2 2",
        r_rise - acc_cyc, resp_rise - rdone_c);
    end
  endtask

  task automatic test_write();
    run_cmd(2'd1, 56'd9, 8'hFF, 8'h3C, 8'h00, o, n, wr, er);
    run_cmd(2'd1, 56'd9, 8'h0F, 8'hA5, 8'h00, o, n, wr, er);
    n_cmp++;
    if (o !== 8'h3C || n !== 8'h35 || wr !== 1'b1 || mem[9] !== 8'h35)
    begin
      n_bad++;
      $display("FAIL write: old=%h new=%h wr=%b mem=%h want 3c 35 1 35",
        o, n, wr, mem[9]);
    end
    n_cmp++;
    if (w_rise - rdone_c != 3 || resp_rise - wdone_c != 1) begin
      n_bad++;
      $display("FAIL write_latency: wv=%0d resp=%0d want 3 1",
        w_rise - rdone_c, resp_rise - wdone_c);
    end
  endtask

  task automatic test_add();
    run_cmd(2'd1, 56'd2, 8'hFF, 8'h1C, 8'h00, o, n, wr, er);
    run_cmd(2'd2, 56'd2, 8'h0F, 8'h09, 8'h00, o, n, wr, er);
    n_cmp++;
    if (o !== 8'h1C || n !== 8'h15 || wr !== 1'b1 || mem[2] !== 8'h15)
    begin
      n_bad++;
      $display("FAIL add: old=%h new=%h wr=%b mem=%h want 1c 15 1 15",
        o, n, wr, mem[2]);
    end
  endtask

  task automatic test_cas();
    run_cmd(2'd1, 56'd4, 8'hFF, 8'h3C, 8'h00, o, n, wr, er);
    run_cmd(2'd3, 56'd4, 8'hFF, 8'h77, 8'h3C, o, n, wr, er);
    n_cmp++;
    if (o !== 8'h3C || n !== 8'h77 || wr !== 1'b1 || mem[4] !== 8'h77)
    begin
      n_bad++;
      $display("FAIL cas_hit: old=%h new=%h wr=%b mem=%h want 3c 77 1 77",
        o, n, wr, mem[4]);
    end
    run_cmd(2'd3, 56'd4, 8'hFF, 8'h11, 8'h3D, o, n, wr, er);
    n_cmp++;
    if (o !== 8'h77 || n !== 8'h77 || wr !== 1'b0 || mem[4] !== 8'h77)
    begin
      n_bad++;
      $display("FAIL cas_miss: old=%h new=%h wr=%b mem=%h want 77 77 0 77",
        o, n, wr, mem[4]);
    end
  endtask

  task automatic test_random();
    logic [7:0] shadow [0:15];
    logic [7:0] m, d, c, en;
    logic [1:0] op;
    int a, bad;
    bit ew;
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 8'($urandom);
      run_cmd(2'd1, 56'(i), 8'hFF, shadow[i], 8'h00, o, n, wr, er);
    end
    bad = 0;
    for (int t = 0; t < 30; t++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 15);
      m  = 8'($urandom);
      d  = 8'($urandom);
      c  = $urandom_range(0, 1) ? (shadow[a] ^ (8'($urandom) & ~m))
                                : 8'($urandom);
      en = ref_new(int'(op), int'(shadow[a]), int'(m), int'(d),
                   int'(c), ew);
      run_cmd(op, 56'(a), m, d, c, o, n, wr, er);
      if (o !== shadow[a] || n !== en || wr !== ew || er !== 1'b0) begin
        bad++;
        $display("FAIL rand_resp: op=%0d old=%h/%h new=%h/%h wr=%b/%b",
          op, o, shadow[a], n, en, wr, ew);
      end
      if (ew) shadow[a] = en;
      if (mem[a] !== shadow[a]) begin
        bad++;
        $display("FAIL rand_mem: addr=%0d got %h want %h",
          a, mem[a], shadow[a]);
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL random: %0d bad transactions want 0", bad);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] so, sn;
    logic sw, se;
    bit unstable, rdy;
    int k;
    run_cmd(2'd1, 56'd3, 8'hFF, 8'h50, 8'h00, o, n, wr, er);
    @(negedge clk);
    cmd_op = 2'd1; cmd_addr = 56'd3; cmd_mask = 8'hF0;
    cmd_data = 8'hA7; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    cmd_op = 2'd0;
    k = 0;
    while (!resp_valid && k < 200) begin @(negedge clk); k++; end
    so = resp_old; sn = resp_new; sw = resp_wrote; se = resp_err;
    n_cmp++;
    if (so !== 8'h50 || sn !== 8'hA0 || sw !== 1'b1 || se !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_resp: old=%h new=%h wr=%b err=%b want 50 a0 1 0",
        so, sn, sw, se);
    end
    unstable = 0; rdy = 0;
    repeat (10) begin
      @(negedge clk);
      if (!resp_valid || resp_old !== so || resp_new !== sn ||
          resp_wrote !== sw || resp_err !== se) unstable = 1;
      if (cmd_ready) rdy = 1;
    end
    n_cmp++;
    if (unstable || rdy) begin
      n_bad++;
      $display("FAIL bp_hold: unstable=%0b cmd_ready_seen=%0b want 0 0",
        unstable, rdy);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_reaccept: cmd_ready=%b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (!resp_valid && k < 200) begin @(negedge clk); k++; end
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_old !== 8'hA0 || resp_wrote !== 1'b0)
    begin
      n_bad++;
      $display("FAIL bp_next: valid=%b old=%h wr=%b want 1 a0 0",
        resp_valid, resp_old, resp_wrote);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    cmd_op = 2'd1; cmd_addr = 56'd7; cmd_mask = 8'hFF;
    cmd_data = 8'h99; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (!rw_w_valid && k < 50) begin @(negedge clk); k++; end
    n_cmp++;
    if (rw_w_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_reach: w_valid=%b want 1", rw_w_valid);
    end
    rst_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rw_r_valid, rw_w_valid, resp_valid, cmd_ready} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_mid_valids: got %b want 0000",
        {rw_r_valid, rw_w_valid, resp_valid, cmd_ready});
    end
    rst_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_idle: cmd_ready=%b want 1", cmd_ready);
    end
    run_cmd(2'd1, 56'd7, 8'hFF, 8'h42, 8'h00, o, n, wr, er);
    run_cmd(2'd0, 56'd7, 8'h00, 8'h00, 8'h00, o, n, wr, er);
    n_cmp++;
    if (o !== 8'h42 || wr !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_after: old=%h wr=%b want 42 0", o, wr);
    end
  endtask

  task automatic test_timeout();
    int r0;
    run_cmd(2'd1, 56'd6, 8'hFF, 8'h5A, 8'h00, o, n, wr, er);
    hang_r = 1'b1;
    r0 = r_hi;
    run_cmd(2'd1, 56'd6, 8'hFF, 8'h01, 8'h00, o, n, wr, er);
    n_cmp++;
    if (er !== 1'b1 || wr !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_resp: err=%b wr=%b want 1 0", er, wr);
    end
    n_cmp++;
    if (r_hi - r0 != 8 || mem[6] !== 8'h5A) begin
      n_bad++;
      $display("FAIL timeout_valid: rcycles=%0d mem=%h want 8 5a",
        r_hi - r0, mem[6]);
    end
    hang_r = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_add();
    test_cas();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hawk_struct_rmw.md
# hawk_struct_rmw

Single-outstanding read-modify-write sequencer that sits directly upstream of `hawk_struct_rw`. It accepts one atomic struct command at a time (READ, masked WRITE, masked ADD, masked CAS) on a valid/ready port. It drives the `hawk_struct_rw` read side, computes the new value, drives the write side when required, and returns the old and new values on a response port. Hawk control logic (page-table, free-list and attribute-table updates) uses it so that no client hand-sequences the struct_rw handshakes.

## Interface
Parameters:
- `STRUCT_WIDTH`, 8: struct width in bits; must match the attached `hawk_struct_rw`.
- `ADDR_WIDTH`, 64 - `STRUCT_WIDTH`: struct-index address width.
- `TIMEOUT_CYCLES`, 1024: maximum wait for `r_done`/`w_done`; 0 disables the timeout.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted when valid && ready.
- `cmd_op`  in  2  0 READ, 1 WRITE, 2 ADD, 3 CAS.
- `cmd_addr`  in  `ADDR_WIDTH`  struct index.
- `cmd_mask`  in  `STRUCT_WIDTH`  field mask.
- `cmd_data`  in  `STRUCT_WIDTH`  write value or addend.
- `cmd_cmp`  in  `STRUCT_WIDTH`  CAS compare value.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response consumed.
- `resp_old`  out  `STRUCT_WIDTH`  value read from memory.
- `resp_new`  out  `STRUCT_WIDTH`  value written; equals old if no write was issued.
- `resp_wrote`  out  1  a write was issued and completed.
- `resp_err`  out  1  timeout occurred.
- `rw_r_addr_array`, `rw_w_addr_array`  out  `ADDR_WIDTH`  latched `cmd_addr`.
- `rw_r_valid`, `rw_w_valid`  out  1  request to struct_rw.
- `rw_w_array`  out  `STRUCT_WIDTH`  new value.
- `rw_r_array`  in  `STRUCT_WIDTH`  read data.
- `rw_r_done`, `rw_w_done`, `rw_r_ready`, `rw_w_ready`  in  1  struct_rw status.

## Operation
- States:
  - IDLE: `cmd_ready`=1. On a cmd handshake, latch op/addr/mask/data/cmp and go to RD.
  - RD: wait for `rw_r_ready`=1, then go to RD_WAIT.
  - RD_WAIT: `rw_r_valid`=1. On `rw_r_done`, capture `rw_r_array` into old, drop valid and go to MOD.
  - MOD: register new. If READ, or CAS with a mismatch, go to RESP with `resp_wrote`=0. Otherwise go to WR.
  - WR: wait for `rw_w_ready`, then go to WR_WAIT.
  - WR_WAIT: `rw_w_valid`=1. On `rw_w_done`, drop valid, set wrote=1 and go to RESP.
  - RESP: `resp_valid`=1, held until `resp_ready`, then go to IDLE.
- New-value rules (width `STRUCT_WIDTH`):
  - WRITE: `(old & ~mask) | (data & mask)`.
  - ADD: `(old & ~mask) | ((old + data) & mask)`; the sum is modulo 2^`STRUCT_WIDTH` and carries outside the mask are discarded.
  - CAS: the write happens iff `(old & mask) == (cmp & mask)`, and then behaves as WRITE.
  - READ: new = old.
- Valid-drop handshake: struct_rw returns to ready only after `done` is seen with valid low. The block therefore deasserts valid in the cycle after `done`, and never reasserts it until ready=1.
- Address outputs and `rw_w_array` stay stable from command latch until RESP.
- Timeout: a counter clears on entry to RD_WAIT/WR_WAIT and increments each waiting cycle. When it reaches `TIMEOUT_CYCLES`-1 without `done`, the block:
  - drops valid;
  - sets `resp_err`=1 and leaves `resp_wrote` at its current value;
  - goes to RESP.

  The next RD/WR still waits on ready, so a hung struct_rw blocks later commands rather than corrupting them.

## Timing
- Reset values:
  - `cmd_ready`=0 during reset and 1 in the first cycle after it.
  - `resp_valid`=0, `rw_r_valid`=0, `rw_w_valid`=0.
  - `resp_old`, `resp_new`, `resp_wrote`, `resp_err` = 0.
  - Addresses and `rw_w_array` = 0.
  - State IDLE, counter 0.
- Reset mid-operation returns to IDLE and drops all valids the next cycle. The integrator must reset struct_rw together with this block.
- Latency with ready=1 throughout:
  - Accept at T; `rw_r_valid` is high at T+2.
  - `r_done` at Tr gives MOD at Tr+1 and `rw_w_valid` at Tr+3.
  - `w_done` at Tw gives `resp_valid` at Tw+1.
  - A READ with `r_done` at Tr gives `resp_valid` at Tr+2.
- `cmd_ready` is high only in IDLE, so there is one command in flight and no address hazards.
- `resp_*` are stable while `resp_valid`=1 && !`resp_ready`.
- `cmd_valid` held during RESP is accepted in the cycle after the response handshake.

## Structure
- `hacd_pkg` holds:
  - `hawk_rmw_op_t` (enum: READ/WRITE/ADD/CAS);
  - `hawk_rmw_state_t`;
  - a `hawk_rmw_cmd_t` packed struct (op, addr, mask, data, cmp).
- The new-value computation is a natural sub-module, `hawk_rmw_alu`: combinational, with inputs op/old/mask/data/cmp and outputs new/do_write.
- Top level: one `hawk_struct_rmw` instance wired to one `hawk_struct_rw` instance.

## Test plan
All scenarios use `STRUCT_WIDTH`=8 with a struct_rw model responding with 3-cycle done latency.
- READ addr 5, memory 0x3C -> `resp_old`=0x3C, `resp_new`=0x3C, `resp_wrote`=0; `rw_w_valid` never asserted.
- WRITE mask 0x0F, data 0xA5, memory 0x3C -> write 0x35; resp old 0x3C, new 0x35, wrote=1.
- ADD mask 0x0F, data 0x09, memory 0x1C -> write 0x15 (carry discarded), wrote=1.
- CAS mask 0xFF: cmp 0x3C on 0x3C -> write data 0x77 with wrote=1; cmp 0x3D -> no write, wrote=0.
- `TIMEOUT_CYCLES`=8 with the model never asserting `r_done` -> `rw_r_valid` drops after 8 cycles, then `resp_err`=1, `resp_wrote`=0.
- Backpressure and reset:
  - `resp_ready`=0 for 10 cycles -> resp fields stable, `cmd_ready`=0.
  - `rst_i` asserted in WR_WAIT -> the next cycle all valids are 0 and state is IDLE.
